// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES job scheduler.
// Optional watchdog in the top is enabled with AES_JOB_SCHED_TIMEOUT_EN.
package aes_sched_pkg;

   localparam int AES_BLK_W = 128;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } sched_state_t;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
// Produces a one-hot grant plus its index; the pointer register lives in the parent.
module aes_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               grant_valid
);

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [2*NUM_REQ-1:0] req_shift;
   logic [NUM_REQ-1:0]   req_rot;
   logic [ID_W-1:0]      off;
   logic [ID_W:0]        idx_sum;

   // Rotating the doubled vector puts requester ptr at bit 0 of req_rot.
   assign req_dbl   = {req, req};
   assign req_shift = req_dbl >> ptr;
   assign req_rot   = req_shift[NUM_REQ-1:0];

   always_comb begin
      off         = '0;
      grant_valid = 1'b0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req_rot[j]) begin
            off         = ID_W'(j);
            grant_valid = 1'b1;
         end
      end
   end

   always_comb begin
      idx_sum = {1'b0, ptr} + {1'b0, off};
      if (idx_sum >= (ID_W+1)'(NUM_REQ)) begin
         idx_sum = idx_sum - (ID_W+1)'(NUM_REQ);
      end
   end

   assign grant_idx = idx_sum[ID_W-1:0];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign grant[gi] = grant_valid && (grant_idx == ID_W'(gi));
   end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one AES core among NUM_REQ requesters: round-robin accept, start, wait, respond.
// Define AES_JOB_SCHED_TIMEOUT_EN to add a START-to-DONE watchdog that reports via RSP_ERR.
module aes_job_scheduler
   import aes_sched_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = $clog2(NUM_REQ),
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic                         CLK,
   input  logic                         nRST,
   input  logic [NUM_REQ-1:0]           REQ_VALID,
   output logic [NUM_REQ-1:0]           REQ_READY,
   input  logic [NUM_REQ-1:0]           REQ_ENCDEC,
   input  logic [AES_BLK_W*NUM_REQ-1:0] REQ_KEY,
   input  logic [AES_BLK_W*NUM_REQ-1:0] REQ_TEXT,
   output logic                         RSP_VALID,
   input  logic                         RSP_READY,
   output logic [ID_W-1:0]              RSP_ID,
   output logic [AES_BLK_W-1:0]         RSP_TEXT,
   output logic                         RSP_ERR,
   output logic                         AES_START,
   output logic                         AES_ENCDEC,
   output logic [AES_BLK_W-1:0]         AES_KEY,
   output logic [AES_BLK_W-1:0]         AES_TEXTIN,
   input  logic                         AES_DONE,
   input  logic [AES_BLK_W-1:0]         AES_TEXTOUT,
   output logic                         BUSY
);

   sched_state_t         state_reg, state_next;
   logic [ID_W-1:0]      ptr_reg, ptr_next;
   logic [ID_W-1:0]      id_reg;
   logic                 encdec_reg;
   logic [AES_BLK_W-1:0] key_reg, text_reg, rsp_text_reg;
   logic [NUM_REQ-1:0]   grant;
   logic [ID_W-1:0]      grant_idx;
   logic                 grant_valid;
   logic                 accept, capture, timeout;

   aes_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req         (REQ_VALID),
      .ptr         (ptr_reg),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

`ifdef AES_JOB_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_reg;
   logic             rsp_err_reg;
   logic             timeout_hit;

   assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      capture    = 1'b0;
      timeout    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (grant_valid) begin
               accept     = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: state_next = WAIT;
         WAIT: begin
            if (AES_DONE) begin
               capture    = 1'b1;
               state_next = RESP;
            end
`ifdef AES_JOB_SCHED_TIMEOUT_EN
            else if (timeout_hit) begin
               timeout    = 1'b1;
               state_next = RESP;
            end
`endif
         end
         RESP: begin
            if (RSP_READY) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg    <= IDLE;
         ptr_reg      <= '0;
         id_reg       <= '0;
         encdec_reg   <= 1'b0;
         key_reg      <= '0;
         text_reg     <= '0;
         rsp_text_reg <= '0;
`ifdef AES_JOB_SCHED_TIMEOUT_EN
         cnt_reg      <= '0;
         rsp_err_reg  <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         if (accept) begin
            ptr_reg    <= ptr_next;
            id_reg     <= grant_idx;
            encdec_reg <= REQ_ENCDEC[grant_idx];
            key_reg    <= REQ_KEY[grant_idx*AES_BLK_W +: AES_BLK_W];
            text_reg   <= REQ_TEXT[grant_idx*AES_BLK_W +: AES_BLK_W];
         end
         if (capture) rsp_text_reg <= AES_TEXTOUT;
`ifdef AES_JOB_SCHED_TIMEOUT_EN
         if (state_reg == ISSUE)     cnt_reg <= '0;
         else if (state_reg == WAIT) cnt_reg <= cnt_reg + CNT_W'(1);
         if (capture) rsp_err_reg <= 1'b0;
         if (timeout) begin
            rsp_err_reg  <= 1'b1;
            rsp_text_reg <= '0;
         end
`endif
      end
   end

   // Gating with nRST keeps REQ_READY low while reset is held, even though IDLE is combinational.
   assign REQ_READY  = (state_reg == IDLE && nRST) ? grant : '0;
   assign AES_START  = (state_reg == ISSUE);
   assign RSP_VALID  = (state_reg == RESP);
   assign BUSY       = (state_reg != IDLE);
   assign RSP_ID     = id_reg;
   assign RSP_TEXT   = rsp_text_reg;
   assign AES_ENCDEC = encdec_reg;
   assign AES_KEY    = key_reg;
   assign AES_TEXTIN = text_reg;

`ifdef AES_JOB_SCHED_TIMEOUT_EN
   assign RSP_ERR = rsp_err_reg;
`else
   // Evaluates to 0 for any legal limit; the limit only matters with the watchdog.
   assign RSP_ERR = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed bench for aes_job_scheduler with a behavioural core (TEXTOUT = TEXTIN ^ KEY, DONE 12 cycles after START).
// Watchdog checks run only when AES_JOB_SCHED_TIMEOUT_EN is defined.
module tb_aes_job_scheduler;

   localparam int N = 4;

   logic           CLK = 1'b0;
   logic           nRST = 1'b0;
   logic [N-1:0]   REQ_VALID = '0;
   logic [N-1:0]   REQ_READY;
   logic [N-1:0]   REQ_ENCDEC = '0;
   logic [128*N-1:0] REQ_KEY = '0;
   logic [128*N-1:0] REQ_TEXT = '0;
   logic           RSP_VALID;
   logic           RSP_READY = 1'b0;
   logic [1:0]     RSP_ID;
   logic [127:0]   RSP_TEXT;
   logic           RSP_ERR;
   logic           AES_START;
   logic           AES_ENCDEC;
   logic [127:0]   AES_KEY;
   logic [127:0]   AES_TEXTIN;
   logic           AES_DONE;
   logic [127:0]   AES_TEXTOUT;
   logic           BUSY;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   aes_job_scheduler #(
      .NUM_REQ        (N),
      .ID_W           (2),
      .TIMEOUT_CYCLES (32)
   ) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .REQ_VALID   (REQ_VALID),
      .REQ_READY   (REQ_READY),
      .REQ_ENCDEC  (REQ_ENCDEC),
      .REQ_KEY     (REQ_KEY),
      .REQ_TEXT    (REQ_TEXT),
      .RSP_VALID   (RSP_VALID),
      .RSP_READY   (RSP_READY),
      .RSP_ID      (RSP_ID),
      .RSP_TEXT    (RSP_TEXT),
      .RSP_ERR     (RSP_ERR),
      .AES_START   (AES_START),
      .AES_ENCDEC  (AES_ENCDEC),
      .AES_KEY     (AES_KEY),
      .AES_TEXTIN  (AES_TEXTIN),
      .AES_DONE    (AES_DONE),
      .AES_TEXTOUT (AES_TEXTOUT),
      .BUSY        (BUSY)
   );

   // Core model
   int   dcnt = 0;
   int   start_cnt = 0;
   logic model_on = 1'b1;
   logic late_done = 1'b0;

   always @(posedge CLK) begin
      if (AES_START) begin
         dcnt      <= 12;
         start_cnt <= start_cnt + 1;
      end else if (dcnt > 0) begin
         dcnt <= dcnt - 1;
      end
   end

   assign AES_DONE    = (model_on && dcnt == 1) || late_done;
   assign AES_TEXTOUT = AES_DONE ? (AES_TEXTIN ^ AES_KEY) : 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

   typedef struct packed {
      logic [3:0]   valid;
      logic [1:0]   id;
      logic         enc;
      logic [127:0] key;
      logic [127:0] text;
      logic [127:0] exp;
   } vec_t;

   vec_t tbl [5];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_rsp(output int cyc);
      cyc = 0;
      while (!RSP_VALID && cyc < 200) begin
         @(negedge CLK);
         cyc++;
      end
      if (!RSP_VALID) begin
         n_checks++;
         n_fail++;
         $display("FAIL rsp_wait: got no RSP_VALID required RSP_VALID within 200 cycles");
      end
   endtask

   task automatic rsp_ack();
      RSP_READY = 1'b1;
      @(posedge CLK);
      #1;
      RSP_READY = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, REQ_READY, 0);
      chk({tag, "_rsp_valid"}, RSP_VALID, 0);
      chk({tag, "_rsp_id"}, RSP_ID, 0);
      chk({tag, "_rsp_text"}, RSP_TEXT, 0);
      chk({tag, "_rsp_err"}, RSP_ERR, 0);
      chk({tag, "_aes_start"}, AES_START, 0);
      chk({tag, "_aes_encdec"}, AES_ENCDEC, 0);
      chk({tag, "_aes_key"}, AES_KEY, 0);
      chk({tag, "_aes_textin"}, AES_TEXTIN, 0);
      chk({tag, "_busy"}, BUSY, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cyc;
      int   s0;
      int   bad;
      logic [127:0] exp_t;

      // Table rows assume the pointer is 0 when the table starts.
      tbl[0] = '{4'b0100, 2'd2, 1'b0, 128'h0, 128'h1234, 128'h1234};
      tbl[1] = '{4'b0011, 2'd0, 1'b1, 128'hFF00, 128'h00FF, 128'hFFFF};
      tbl[2] = '{4'b1001, 2'd3, 1'b0, 128'hF0000000_00000000_00000000_00000001,
                 128'h0F000000_00000000_00000000_00000002, 128'hFF000000_00000000_00000000_00000003};
      tbl[3] = '{4'b0110, 2'd1, 1'b1, 128'h12345678_00000000_00000000_00000000,
                 128'h12345678_00000000_00000000_0000ABCD, 128'h00000000_00000000_00000000_0000ABCD};
      tbl[4] = '{4'b0011, 2'd0, 1'b0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
                 128'h0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF};

      // Reset state with all requesters pending
      REQ_VALID = 4'b1111;
      #7;
      chk_all_zero("reset");
      @(negedge CLK);
      nRST = 1'b1;

      // Fairness: all requesters held valid for eight jobs
      for (int i = 0; i < N; i++) begin
         REQ_KEY[128*i +: 128]  = 128'(i + 1) << 64;
         REQ_TEXT[128*i +: 128] = 128'(16 * (i + 1));
      end
      s0 = start_cnt;
      for (int j = 0; j < 8; j++) begin
         wait_rsp(cyc);
         exp_t = (128'((j % 4) + 1) << 64) ^ 128'(16 * ((j % 4) + 1));
         $display("fair job %0d: id=%0d text=%0h", j, RSP_ID, RSP_TEXT);
         chk("fair_id", RSP_ID, 128'(j % 4));
         chk("fair_text", RSP_TEXT, exp_t);
         rsp_ack();
         chk("fair_next_grant", REQ_READY, 128'(4'b0001 << ((j + 1) % 4)));
         if (j == 7) REQ_VALID = '0;
      end
      @(negedge CLK);
      chk("fair_start_count", 128'(start_cnt - s0), 128'd8);

      // Table-driven single jobs
      for (int v = 0; v < 5; v++) begin
         @(posedge CLK);
         #1;
         for (int i = 0; i < N; i++) begin
            if (i == int'(tbl[v].id)) begin
               REQ_KEY[128*i +: 128]  = tbl[v].key;
               REQ_TEXT[128*i +: 128] = tbl[v].text;
               REQ_ENCDEC[i]          = tbl[v].enc;
            end else begin
               REQ_KEY[128*i +: 128]  = ~tbl[v].key;
               REQ_TEXT[128*i +: 128] = ~tbl[v].text;
               REQ_ENCDEC[i]          = ~tbl[v].enc;
            end
         end
         REQ_VALID = tbl[v].valid;
         @(negedge CLK);
         chk("vec_ready", REQ_READY, 128'(4'b0001 << tbl[v].id));
         chk("vec_idle_busy", BUSY, 0);
         s0 = start_cnt;
         @(posedge CLK);
         #1;
         REQ_VALID = '0;
         chk("vec_start", AES_START, 1);
         chk("vec_encdec", AES_ENCDEC, tbl[v].enc);
         chk("vec_busy", BUSY, 1);
         chk("vec_ready_busy", REQ_READY, 0);
         wait_rsp(cyc);
         $display("vec %0d: id=%0d text=%0h err=%0d latency=%0d", v, RSP_ID, RSP_TEXT, RSP_ERR, cyc + 1);
         chk("vec_latency", 128'(cyc + 1), 128'd15);
         chk("vec_id", RSP_ID, tbl[v].id);
         chk("vec_text", RSP_TEXT, tbl[v].exp);
         chk("vec_err", RSP_ERR, 0);
         chk("vec_start_count", 128'(start_cnt - s0), 128'd1);
         rsp_ack();
      end

      // Backpressure: pointer is 1 here, requester 2 runs, requester 1 waits behind it
      REQ_KEY[128*2 +: 128]  = 128'hAAAA;
      REQ_TEXT[128*2 +: 128] = 128'h5555;
      REQ_KEY[128*1 +: 128]  = 128'h0F0F;
      REQ_TEXT[128*1 +: 128] = 128'h00FF;
      REQ_VALID = 4'b0100;
      @(posedge CLK);
      #1;
      REQ_VALID = '0;
      wait_rsp(cyc);
      REQ_VALID = 4'b0010;
      s0 = start_cnt;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         chk("bp_valid", RSP_VALID, 1);
         chk("bp_text", {RSP_TEXT[125:0], RSP_ID}, {128'hFFFF, 2'd2});
         chk("bp_ready", REQ_READY, 0);
      end
      chk("bp_no_start", 128'(start_cnt - s0), 0);
      $display("backpressure: id=%0d text=%0h held 20 cycles", RSP_ID, RSP_TEXT);
      rsp_ack();
      chk("bp_next_grant", REQ_READY, 128'(4'b0010));
      @(posedge CLK);
      #1;
      REQ_VALID = '0;
      wait_rsp(cyc);
      $display("backpressure follow-up: id=%0d text=%0h", RSP_ID, RSP_TEXT);
      chk("bp_follow_id", RSP_ID, 1);
      chk("bp_follow_text", RSP_TEXT, 128'h0FF0);
      rsp_ack();

      // Reset during WAIT: pointer is 2, requester 0 is the only one valid
      REQ_KEY[127:0]  = 128'h1111;
      REQ_TEXT[127:0] = 128'h2222;
      REQ_VALID = 4'b0001;
      @(posedge CLK);
      #1;
      REQ_VALID = '0;
      @(posedge CLK);
      repeat (4) @(posedge CLK);
      #2;
      REQ_VALID = 4'b1111;
      nRST = 1'b0;
      #1;
      $display("reset mid-wait applied");
      chk_all_zero("midrst");
      REQ_VALID = '0;
      @(negedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
      bad = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge CLK);
         if (RSP_VALID || BUSY) bad++;
      end
      chk("midrst_no_rsp", 128'(bad), 0);
      @(posedge CLK);
      #1;
      REQ_VALID = 4'b1111;
      @(negedge CLK);
      chk("midrst_ptr_zero", REQ_READY, 128'(4'b0001));
      REQ_VALID = '0;

`ifdef AES_JOB_SCHED_TIMEOUT_EN
      // Watchdog: core never answers; pointer is still 0
      model_on = 1'b0;
      REQ_VALID = 4'b0100;
      @(posedge CLK);
      #1;
      REQ_VALID = '0;
      wait_rsp(cyc);
      $display("timeout: id=%0d text=%0h err=%0d after %0d cycles", RSP_ID, RSP_TEXT, RSP_ERR, cyc);
      chk("to_not_early", 128'(cyc >= 32), 1);
      chk("to_err", RSP_ERR, 1);
      chk("to_text", RSP_TEXT, 0);
      chk("to_id", RSP_ID, 2);
      late_done = 1'b1;
      @(negedge CLK);
      late_done = 1'b0;
      @(negedge CLK);
      chk("to_late_err", RSP_ERR, 1);
      chk("to_late_text", RSP_TEXT, 0);
      rsp_ack();
      late_done = 1'b1;
      @(negedge CLK);
      late_done = 1'b0;
      @(negedge CLK);
      chk("to_late_idle", {BUSY, RSP_VALID}, 0);
      model_on = 1'b1;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
